// File: rtl/lcd_text_buffer_if.sv
// Bundle of signals between lcd_text_buffer, its host and the downstream SC1602 driver.
// The master is the host/driver side; the slave is the buffer itself.
interface lcd_text_buffer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_req;
  logic       clr_busy;
  logic       shift_req;
  logic       shift_dir;
  logic       shift_busy;
  logic       drawing;
  logic       ready_o;
  logic [7:0] character;
  logic [2:0] command_in;

  modport master (
    output wr_en, wr_addr, wr_data, clr_req, shift_req, shift_dir, drawing, ready_o,
    input  clr_busy, shift_busy, character, command_in
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_req, shift_req, shift_dir, drawing, ready_o,
    output clr_busy, shift_busy, character, command_in
  );
endinterface

// File: rtl/lcd_text_buffer.sv
// 32-cell character buffer feeding the SC1602 driver in refresh order, with a clear/fill
// engine and a display-shift command handshake on the driver's command_in.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter bit         RESET_CLEAR = 1'b1
) (
  input logic               clk,
  input logic               reset,
  lcd_text_buffer_if.slave  bus
);

  typedef enum logic {CIdle, CFill} clr_state_e;
  typedef enum logic [1:0] {SIdle, SIssue, SWait} shift_state_e;

  logic [7:0]   mem [32];

  clr_state_e   clr_state_q, clr_state_d;
  logic [4:0]   fill_idx_q, fill_idx_d;
  logic         clr_busy;

  shift_state_e shift_state_q, shift_state_d;
  logic         shift_dir_q, shift_dir_d;
  logic         shift_busy;
  logic [2:0]   command_in;

  logic [4:0]   rd_idx_q;
  logic         drawing_q;
  logic         ready_q;
  logic [7:0]   character_q;

  assign clr_busy = (clr_state_q == CFill);

  // Clear engine
  always_comb begin
    clr_state_d = clr_state_q;
    fill_idx_d  = fill_idx_q;
    unique case (clr_state_q)
      CIdle: begin
        if (bus.clr_req) begin
          clr_state_d = CFill;
          fill_idx_d  = 5'd0;
        end
      end
      CFill: begin
        fill_idx_d = fill_idx_q + 5'd1;
        if (fill_idx_q == 5'd31) clr_state_d = CIdle;
      end
      default: clr_state_d = CIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q <= RESET_CLEAR ? CFill : CIdle;
      fill_idx_q  <= 5'd0;
    end else begin
      clr_state_q <= clr_state_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  // Host writes are dropped while the fill owns the write port.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem[fill_idx_q] <= FILL_CHAR;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read side: follow the driver's nibble writes; a ready rise re-aligns to frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx_q    <= 5'd0;
      drawing_q   <= 1'b0;
      ready_q     <= 1'b0;
      character_q <= FILL_CHAR;
    end else begin
      drawing_q <= bus.drawing;
      ready_q   <= bus.ready_o;
      if (bus.ready_o && !ready_q) begin
        rd_idx_q <= 5'd0;
      end else if (drawing_q && !bus.drawing) begin
        rd_idx_q <= rd_idx_q + 5'd1;
      end
      // Hold across both nibbles so one cell never mixes two codes.
      if (!bus.drawing && !drawing_q) begin
        character_q <= mem[rd_idx_q];
      end
    end
  end

  // Shift handshake
  always_comb begin
    shift_state_d = shift_state_q;
    shift_dir_d   = shift_dir_q;
    command_in    = 3'b000;
    shift_busy    = (shift_state_q != SIdle);
    unique case (shift_state_q)
      SIdle: begin
        if (bus.shift_req && !clr_busy) begin
          shift_dir_d   = bus.shift_dir;
          shift_state_d = SIssue;
        end
      end
      SIssue: begin
        command_in = {2'b01, shift_dir_q};
        if (!bus.ready_o) shift_state_d = SWait;
      end
      SWait: begin
        if (bus.ready_o) shift_state_d = SIdle;
      end
      default: shift_state_d = SIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_state_q <= SIdle;
      shift_dir_q   <= 1'b0;
    end else begin
      shift_state_q <= shift_state_d;
      shift_dir_q   <= shift_dir_d;
    end
  end

  assign bus.clr_busy   = clr_busy;
  assign bus.shift_busy = shift_busy;
  assign bus.character  = character_q;
  assign bus.command_in = command_in;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomized bench for lcd_text_buffer: an array model of the screen plus a fill countdown
// predicts every character and busy flag; the driver side is played by simple tasks.
module tb_lcd_text_buffer;
  localparam logic [7:0] Fill = 8'h20;

  logic clk = 1'b0;
  logic reset;

  lcd_text_buffer_if bus ();

  lcd_text_buffer #(
    .FILL_CHAR  (Fill),
    .RESET_CLEAR(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;
  logic [7:0]  ref_mem [32];
  int          ref_clr_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: update the model from the inputs presented now, clock, check clr_busy,
  // then drop the one-cycle strobes.
  task automatic step();
    if (reset) begin
      ref_clr_left = 32;
    end else if (ref_clr_left > 0) begin
      ref_mem[32 - ref_clr_left] = Fill;
      ref_clr_left--;
    end else begin
      if (bus.wr_en) ref_mem[bus.wr_addr] = bus.wr_data;
      if (bus.clr_req) ref_clr_left = 32;
    end
    @(posedge clk);
    #1;
    check_eq("clr_busy", 32'(bus.clr_busy), 32'(ref_clr_left > 0));
    reset         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.clr_req   = 1'b0;
    bus.shift_req = 1'b0;
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
  endtask

  // Plays one driver frame of 32 cells; optionally writes poke_idx while it is being drawn.
  task automatic read_frame(input int poke_idx, input logic [7:0] poke_val);
    logic [7:0] exp;
    bus.drawing = 1'b0;
    bus.ready_o = 1'b0;
    step();
    bus.ready_o = 1'b1;
    step();
    step();
    for (int i = 0; i < 32; i++) begin
      exp = ref_mem[i];
      check_eq($sformatf("frame_char[%0d]", i), 32'(bus.character), 32'(exp));
      bus.drawing = 1'b1;
      step();
      if (i == poke_idx) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(i);
        bus.wr_data = poke_val;
      end
      step();
      check_eq($sformatf("draw_hold[%0d]", i), 32'(bus.character), 32'(exp));
      bus.drawing = 1'b0;
      step();
      step();
    end
    check_eq("rd_wrap", 32'(bus.character), 32'(ref_mem[0]));
  endtask

  task automatic shift_test(input bit pre_low);
    logic dir;
    dir = 1'($urandom);
    bus.ready_o   = pre_low ? 1'b0 : 1'b1;
    bus.shift_dir = dir;
    bus.shift_req = 1'b1;
    step();
    check_eq("shift_busy_accept", 32'(bus.shift_busy), 32'd1);
    check_eq("shift_cmd_issue", 32'(bus.command_in), 32'({2'b01, dir}));
    if (!pre_low) begin
      repeat ($urandom_range(1, 4)) begin
        step();
        check_eq("shift_cmd_held", 32'(bus.command_in), 32'({2'b01, dir}));
      end
      bus.ready_o = 1'b0;
    end
    step();
    check_eq("shift_cmd_wait", 32'(bus.command_in), 32'd0);
    check_eq("shift_busy_wait", 32'(bus.shift_busy), 32'd1);
    bus.shift_req = 1'b1;
    bus.shift_dir = ~dir;
    step();
    check_eq("shift_drop_cmd", 32'(bus.command_in), 32'd0);
    check_eq("shift_drop_busy", 32'(bus.shift_busy), 32'd1);
    repeat ($urandom_range(0, 3)) step();
    bus.ready_o = 1'b1;
    step();
    check_eq("shift_busy_done", 32'(bus.shift_busy), 32'd0);
    check_eq("shift_cmd_done", 32'(bus.command_in), 32'd0);
    step();
    check_eq("shift_no_reissue", 32'(bus.command_in), 32'd0);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    ref_clr_left  = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 8'h00;
    bus.clr_req   = 1'b0;
    bus.shift_req = 1'b0;
    bus.shift_dir = 1'b0;
    bus.drawing   = 1'b0;
    bus.ready_o   = 1'b1;
    reset         = 1'b1;

    // Reset with automatic clear
    step();
    check_eq("rst_character", 32'(bus.character), 32'(Fill));
    check_eq("rst_command", 32'(bus.command_in), 32'd0);
    check_eq("rst_shift_busy", 32'(bus.shift_busy), 32'd0);
    repeat (32) step();
    check_eq("post_clr_command", 32'(bus.command_in), 32'd0);
    read_frame(-1, 8'h00);

    // Directed writes across both rows
    host_write(5'd0, 8'h41);
    host_write(5'd1, 8'h42);
    host_write(5'd16, 8'h43);
    read_frame(-1, 8'h00);

    // Random writes, each frame with a mid-draw poke (cell 5 first)
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(4, 12)) host_write(5'($urandom), 8'($urandom));
      read_frame((r == 0) ? 5 : int'($urandom_range(0, 31)), 8'($urandom));
    end
    read_frame(-1, 8'h00);

    // Display shift handshake
    shift_test(1'b0);
    shift_test(1'b1);
    shift_test(1'b0);

    // Clear with a simultaneous write, plus writes and a shift request during the fill
    bus.clr_req = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'($urandom);
    bus.wr_data = 8'($urandom);
    step();
    for (int k = 0; k < 32; k++) begin
      bus.wr_en   = 1'($urandom);
      bus.wr_addr = 5'($urandom);
      bus.wr_data = 8'($urandom);
      if (k == 10) begin
        bus.shift_req = 1'b1;
        bus.shift_dir = 1'($urandom);
      end
      step();
      check_eq("fill_shift_busy", 32'(bus.shift_busy), 32'd0);
      check_eq("fill_command", 32'(bus.command_in), 32'd0);
    end
    read_frame(-1, 8'h00);

    // Reset during S_ISSUE, then reset again at fill index 10
    repeat (8) host_write(5'($urandom), 8'($urandom));
    bus.ready_o   = 1'b1;
    bus.shift_dir = 1'b1;
    bus.shift_req = 1'b1;
    step();
    check_eq("pre_rst_cmd", 32'(bus.command_in), 32'b011);
    reset = 1'b1;
    step();
    check_eq("rst_issue_cmd", 32'(bus.command_in), 32'd0);
    check_eq("rst_issue_busy", 32'(bus.shift_busy), 32'd0);
    repeat (10) step();
    reset = 1'b1;
    step();
    check_eq("rst_fill_character", 32'(bus.character), 32'(Fill));
    repeat (32) step();
    read_frame(-1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
